lcd_xfer_timing: RTL
====================

Name: lcd_xfer_timing

Overview:
Parametrised LCD write-timing engine that turns one command/data byte into correctly timed LCD bus activity. It drives E, RS, RW and the data bus, in either 4-bit mode (two nibbles) or 8-bit mode (one transfer). It adds a START/BUSY/DONE handshake and a selectable long post-delay for clear/home commands. It sits between the LCD command sequencer (init/write FSM) and the LCD pins, and is the generalised successor of the fixed 4-bit timing FSM.

Parameters:
MODE8, 0, 0 = 4-bit interface (high nibble then low nibble); 1 = 8-bit interface (single transfer)
SETUP_CYC, 2, cycles data/RS are stable with E low before each E pulse (≥1)
EN_CYC, 12, cycles E is held high per transfer (≥1)
GAP_CYC, 50, cycles between the high-nibble and low-nibble transfers, MODE8=0 only (≥1)
CMD_CYC, 2000, post-transfer wait for normal commands/data (≥1)
LONG_CYC, 82000, post-transfer wait when LONG is set (≥1)
Derived: BUS_W = MODE8 ? 8 : 4; CNT_W = $clog2(max of all *_CYC)+1

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  reset, asynchronous, active-high
START  in  1  request a transfer; sampled only in IDLE
BYTE  in  8  byte to write; latched when START is accepted
RS_IN  in  1  0 = command, 1 = data; latched with BYTE
LONG  in  1  select LONG_CYC post-delay; latched with BYTE
BUSY  out  1  high whenever state ≠ IDLE
DONE  out  1  one-cycle pulse when the transfer and its post-delay have completed
LCD_E  out  1  LCD enable strobe
LCD_RS  out  1  LCD register select
LCD_RW  out  1  tied 0 (write only)
LCD_D  out  BUS_W  LCD data bus

Behaviour:
- Reset (asynchronous): state=IDLE, counter=0, latches=0. LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_D=0, BUSY=0, DONE=0. A reset mid-transfer drops E at once; no completion pulse is produced.
- Outputs are Moore decodes of the registered state and latches. E must be glitch-free.
- States: IDLE, SETUP_H, EN_H, GAP, SETUP_L, EN_L, WAIT, FIN.
- Phase timing: each timed state lasts exactly its N cycles. Load the counter with N-1 on entry, decrement every cycle, and leave on the cycle the counter reads 0.
- IDLE: if START=1 at a rising edge, latch BYTE/RS_IN/LONG, go to SETUP_H, and load SETUP_CYC-1. Otherwise stay in IDLE.
- SETUP_H (SETUP_CYC): E=0.
- EN_H (EN_CYC): E=1.
- After EN_H: MODE8=1 goes to WAIT; MODE8=0 goes to GAP.
- GAP (GAP_CYC): E=0.
- SETUP_L (SETUP_CYC): E=0.
- EN_L (EN_CYC): E=1.
- WAIT: E=0. Lasts LONG_CYC if the latched LONG=1, otherwise CMD_CYC.
- FIN: DONE=1 for one cycle, then IDLE.
- LCD_D in MODE8=0: byte[7:4] in SETUP_H/EN_H/GAP; byte[3:0] in SETUP_L/EN_L/WAIT/FIN.
- LCD_D in MODE8=1: the full byte in all non-IDLE states.
- In IDLE, LCD_D keeps its last driven value (0 after reset).
- LCD_RS = latched RS in all non-IDLE states; it holds its last value in IDLE.
- The data bus and RS never change while E=1, or in the cycle E falls.
- START while BUSY=1, including during FIN, is ignored and not queued. START held high continuously gives back-to-back transfers with exactly one IDLE cycle between them.
- BYTE, RS_IN and LONG changes after acceptance have no effect on the current transfer.
- Transfer length, from the accepting edge to the return to IDLE:
  - MODE8=0: 2·SETUP_CYC + 2·EN_CYC + GAP_CYC + post + 1. With defaults and LONG=0: 2079 cycles.
  - MODE8=1: SETUP_CYC + EN_CYC + post + 1. With defaults and LONG=0: 2015 cycles.
- Counter arithmetic is unsigned, CNT_W bits, with no wrap in legal use. A parameter value of 0 is illegal; flag it with an elaboration-time check.

Test Plan:
- MODE8=0, defaults: START with BYTE=8'hA5, RS_IN=1, LONG=0. Required:
  - E high for 12 cycles starting 2 cycles after acceptance, with LCD_D=4'hA.
  - Second E pulse of 12 cycles starting 66 cycles after acceptance, with LCD_D=4'h5.
  - RS=1 throughout; DONE pulses exactly 2078 cycles after the accepting edge; BUSY falls the next cycle.
- LONG=1, BYTE=8'h01, RS_IN=0: DONE 82078 cycles after acceptance; RS=0 throughout.
- MODE8=1, BYTE=8'h3C: a single 12-cycle E pulse with LCD_D=8'h3C; DONE at 2014 cycles after acceptance; no second pulse.
- Second START and a BYTE change to 8'hFF while BUSY: no effect; the first transfer's nibbles and timing are unchanged; only one DONE.
- START held high: DONE, one IDLE cycle, then the next transfer's SETUP_H. Period is 2080 cycles between DONE pulses (defaults).
- RST asserted during EN_H: LCD_E, BUSY and DONE go to 0 asynchronously. After release, a new START gives a normal full transfer.

Source files
------------

// File: rtl/lcd_xfer_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_xfer_timing
// Brief    : Timed LCD write of one byte (4- or 8-bit bus) with START/BUSY/DONE
//            handshake and selectable long post-delay for clear/home commands.
// Revision : 1.0 - initial release
// ============================================================================

module lcd_xfer_timing #(
  parameter int unsigned  MODE8     = 0,
  parameter int unsigned  SETUP_CYC = 2,
  parameter int unsigned  EN_CYC    = 12,
  parameter int unsigned  GAP_CYC   = 50,
  parameter int unsigned  CMD_CYC   = 2000,
  parameter int unsigned  LONG_CYC  = 82000,
  localparam int unsigned BUS_W     = (MODE8 != 0) ? 8 : 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [7:0]       BYTE,
  input  logic             RS_IN,
  input  logic             LONG,
  output logic             BUSY,
  output logic             DONE,
  output logic             LCD_E,
  output logic             LCD_RS,
  output logic             LCD_RW,
  output logic [BUS_W-1:0] LCD_D
);

  localparam int unsigned c_max_se   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int unsigned c_max_seg  = (c_max_se > GAP_CYC) ? c_max_se : GAP_CYC;
  localparam int unsigned c_max_post = (CMD_CYC > LONG_CYC) ? CMD_CYC : LONG_CYC;
  localparam int unsigned c_max_cyc  = (c_max_seg > c_max_post) ? c_max_seg : c_max_post;
  localparam int unsigned CNT_W      = $clog2(c_max_cyc) + 1;

  localparam logic [CNT_W-1:0] c_setup_ld = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] c_en_ld    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] c_gap_ld   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] c_cmd_ld   = CNT_W'(CMD_CYC - 1);
  localparam logic [CNT_W-1:0] c_long_ld  = CNT_W'(LONG_CYC - 1);

  if (MODE8 > 1 || SETUP_CYC == 0 || EN_CYC == 0 || GAP_CYC == 0 ||
      CMD_CYC == 0 || LONG_CYC == 0) begin : g_param_check
    $error("lcd_xfer_timing: MODE8 must be 0/1 and every *_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP_H = 3'd1,
    S_EN_H    = 3'd2,
    S_GAP     = 3'd3,
    S_SETUP_L = 3'd4,
    S_EN_L    = 3'd5,
    S_WAIT    = 3'd6,
    S_FIN     = 3'd7
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BUS_W-1:0] r_lo;
  logic             r_long;
  logic             r_rs;
  logic             r_e;
  logic             r_busy;
  logic             r_done;
  logic [BUS_W-1:0] r_d;

  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_post_ld;
  logic [BUS_W-1:0] w_first;
  logic [BUS_W-1:0] w_second;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_post_ld  = r_long ? c_long_ld : c_cmd_ld;

  // Bus halves are picked from BYTE at acceptance; the second half is latched.
  if (MODE8 != 0) begin : g_bus8
    assign w_first  = BYTE;
    assign w_second = BYTE;
  end else begin : g_bus4
    assign w_first  = BYTE[7:4];
    assign w_second = BYTE[3:0];
  end

  // All outputs are registered next to the state so E cannot glitch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lo    <= '0;
      r_long  <= 1'b0;
      r_rs    <= 1'b0;
      r_e     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_lo    <= w_second;
            r_long  <= LONG;
            r_rs    <= RS_IN;
            r_d     <= w_first;
            r_busy  <= 1'b1;
            r_cnt   <= c_setup_ld;
            r_state <= S_SETUP_H;
          end
        end
        S_SETUP_H: begin
          if (w_cnt_zero) begin
            r_e     <= 1'b1;
            r_cnt   <= c_en_ld;
            r_state <= S_EN_H;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_EN_H: begin
          if (w_cnt_zero) begin
            r_e <= 1'b0;
            if (MODE8 != 0) begin
              r_cnt   <= w_post_ld;
              r_state <= S_WAIT;
            end else begin
              r_cnt   <= c_gap_ld;
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (w_cnt_zero) begin
            r_d     <= r_lo;
            r_cnt   <= c_setup_ld;
            r_state <= S_SETUP_L;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SETUP_L: begin
          if (w_cnt_zero) begin
            r_e     <= 1'b1;
            r_cnt   <= c_en_ld;
            r_state <= S_EN_L;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_EN_L: begin
          if (w_cnt_zero) begin
            r_e     <= 1'b0;
            r_cnt   <= w_post_ld;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (w_cnt_zero) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_e     <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign LCD_E  = r_e;
  assign LCD_RS = r_rs;
  assign LCD_RW = 1'b0;
  assign LCD_D  = r_d;

endmodule

`default_nettype wire
